seg7_scan_mux: RTL and testbench

Downstream display stage for the traffic light controller. Takes the four 7-bit segment patterns it produces (HighwayN, CityE, HighwayS, CityW) and time-multiplexes them onto one 4-digit seven-segment module that shares a segment bus and has per-digit enables. Values are snapshotted once per scan frame so a light change mid-frame cannot tear the display. Optional inter-digit blanking suppresses ghosting.

---
 rtl/seg7_scan_mux_if.sv | 39 +++
 rtl/seg7_scan_mux.sv | 119 +++++++++++
 tb/tb_seg7_scan_mux.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_mux_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux_if
// Groups the display-stage signals between the traffic light controller and
// the seven-segment scan multiplexer.
//
// Signals:
//   en          scan enable; low freezes the scan and darkens the display
//   HighwayN    7-bit segment pattern for digit 0 (bit 6 = seg a, 1 = lit)
//   CityE       7-bit segment pattern for digit 1
//   HighwayS    7-bit segment pattern for digit 2
//   CityW       7-bit segment pattern for digit 3
//   seg         shared segment bus to the display
//   an          one-hot, active-high digit enables
//   frame_start one-cycle pulse in the first cycle of each scan frame
//
// Modports:
//   master  the side producing patterns and consuming the display drive
//   slave   the scan multiplexer itself
// ---------------------------------------------------------------------------
interface seg7_scan_mux_if;
    logic       en;
    logic [6:0] HighwayN;
    logic [6:0] CityE;
    logic [6:0] HighwayS;
    logic [6:0] CityW;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_start;

    modport master (
        output en, HighwayN, CityE, HighwayS, CityW,
        input  seg, an, frame_start
    );

    modport slave (
        input  en, HighwayN, CityE, HighwayS, CityW,
        output seg, an, frame_start
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux
// Time-multiplexes four 7-bit segment patterns onto one 4-digit display with
// a shared segment bus. The four patterns are snapshotted once per frame, on
// the wrap out of digit 3, so a change mid-frame never tears the display.
//
// Parameters:
//   SCAN_DIV      clock cycles per digit slot (2..65535)
//   BLANK_CYCLES  leading dark cycles per slot when blanking is built in
//
// Build option:
//   SEG7_BLANK_EN  when defined, the first BLANK_CYCLES cycles of every slot
//                  are forced dark to suppress ghosting between digits.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   seg7_scan_mux_if.slave (en, four patterns in; seg, an,
//         frame_start out, all outputs registered)
// ---------------------------------------------------------------------------
module seg7_scan_mux #(
    parameter int SCAN_DIV     = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_mux_if.slave    bus
);

    localparam int             CW      = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);

    // Elaboration-time guards on the parameter ranges.
    if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_scan_div
        $error("seg7_scan_mux: SCAN_DIV out of range 2..65535");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
        $error("seg7_scan_mux: BLANK_CYCLES must be below SCAN_DIV");
    end

`ifdef SEG7_BLANK_EN
    localparam logic [CW-1:0]  BLANK_LIM = CW'(BLANK_CYCLES);
`endif

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    sh_q [4];
    logic [6:0]    sh_d [4];
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          frame_start_q, frame_start_d;
    logic          lit;

    // Next-state and output decode. Outputs are computed from the post-edge
    // state (the _d values) so that the registered outputs line up with the
    // counter/index they describe. The snapshot feeds sh_d directly, which is
    // why the first cycle of a new frame already shows the new patterns.
    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        sh_d          = sh_q;
        frame_start_d = 1'b0;
        an_d          = '0;
        seg_d         = '0;
        lit           = 1'b1;

        if (bus.en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    sh_d[0]       = bus.HighwayN;
                    sh_d[1]       = bus.CityE;
                    sh_d[2]       = bus.HighwayS;
                    sh_d[3]       = bus.CityW;
                    frame_start_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end

`ifdef SEG7_BLANK_EN
            lit = (cnt_d >= BLANK_LIM);
`else
            lit = 1'b1;
`endif

            if (lit) begin
                an_d  = 4'b0001 << idx_d;
                seg_d = sh_d[idx_d];
            end
        end
    end

    // State and output registers; reset darkens everything and restarts the
    // scan at digit 0 with blank shadows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            sh_q          <= '{default: '0};
            seg_q         <= '0;
            an_q          <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            sh_q          <= sh_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.an          = an_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_mux
// Randomized bench for seg7_scan_mux with SCAN_DIV=4, BLANK_CYCLES=2. A
// reference model tracks the number of enabled edges since reset and derives
// digit, slot position and frame boundaries from it arithmetically; the
// expected outputs go into a queue that a separate monitor drains.
// ---------------------------------------------------------------------------
module tb_seg7_scan_mux;

    localparam int SD    = 4;
    localparam int BC    = 2;
    localparam int FRAME = 4 * SD;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    seg7_scan_mux_if bus ();

    seg7_scan_mux #(
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t       expQ [$];
    int         checks   = 0;
    int         failures = 0;
    int         pos      = 0;
    logic [6:0] shadow [4] = '{default: 7'd0};

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and count it.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive the next cycle's inputs just after a rising edge so they are
    // stable well before the following edge samples them.
    task automatic applyStimulus(input logic enV, input logic [6:0] n,
                                 input logic [6:0] e, input logic [6:0] s,
                                 input logic [6:0] w);
        @(posedge clk);
        #2;
        bus.en       = enV;
        bus.HighwayN = n;
        bus.CityE    = e;
        bus.HighwayS = s;
        bus.CityW    = w;
    endtask

    // Reference model: pos counts enabled edges since reset. Every FRAME-th
    // enabled edge is a frame boundary where the patterns are captured; the
    // digit on display is (pos / SD) mod 4 and the slot position pos mod SD.
    always @(posedge clk) begin
        exp_t e;
        int   digit;
        bit   litV;
        e = '0;
        if (rst) begin
            pos    = 0;
            shadow = '{default: 7'd0};
        end else if (bus.en) begin
            pos++;
            if (pos % FRAME == 0) begin
                shadow[0] = bus.HighwayN;
                shadow[1] = bus.CityE;
                shadow[2] = bus.HighwayS;
                shadow[3] = bus.CityW;
                e.fs      = 1'b1;
            end
            digit = (pos / SD) % 4;
`ifdef SEG7_BLANK_EN
            litV = ((pos % SD) >= BC);
`else
            litV = 1'b1;
`endif
            if (litV) begin
                e.an  = 4'(1 << digit);
                e.seg = shadow[digit];
            end
        end
        expQ.push_back(e);
    end

    // Monitor: on every falling edge take the expectation for the edge just
    // gone and compare it with what the DUT is driving.
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("an", 32'(bus.an), 32'(e.an));
            checkOutput("seg", 32'(bus.seg), 32'(e.seg));
            checkOutput("frame_start", 32'(bus.frame_start), 32'(e.fs));
            checkOutput("an_onehot", 32'($countones(bus.an) <= 1), 32'd1);
        end
    end

    // Random pattern helper: mostly hold, occasionally change one input.
    logic [6:0] rn, re, rs, rw;

    task automatic randomCycles(input int n, input int enPct);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) rn = 7'($urandom);
            if ($urandom_range(0, 7) == 0) re = 7'($urandom);
            if ($urandom_range(0, 7) == 0) rs = 7'($urandom);
            if ($urandom_range(0, 7) == 0) rw = 7'($urandom);
            applyStimulus(($urandom_range(0, 99) < enPct), rn, re, rs, rw);
        end
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop at once.
    task automatic midCycleReset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("rst_an", 32'(bus.an), 32'd0);
        checkOutput("rst_seg", 32'(bus.seg), 32'd0);
        checkOutput("rst_fs", 32'(bus.frame_start), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.HighwayN = '0;
        bus.CityE    = '0;
        bus.HighwayS = '0;
        bus.CityW    = '0;
        rn = 7'b1011111;
        re = 7'b1110111;
        rs = 7'b1110111;
        rw = 7'b1110111;

        repeat (3) @(posedge clk);
        #2;
        rst          = 1'b0;
        bus.en       = 1'b1;
        bus.HighwayN = rn;
        bus.CityE    = re;
        bus.HighwayS = rs;
        bus.CityW    = rw;

        // First frame dark, then the snapshot shows up on digit 0.
        repeat (22) applyStimulus(1'b1, rn, re, rs, rw);

        // Tear check: change HighwayN while digit 2 is on screen.
        for (int i = 0; i < 64 && ((pos / SD) % 4) != 2; i++)
            applyStimulus(1'b1, rn, re, rs, rw);
        rn = 7'b0110011;
        repeat (2 * FRAME) applyStimulus(1'b1, rn, re, rs, rw);

        // Freeze for 5 cycles in the middle of digit 1.
        for (int i = 0; i < 64 && !(((pos / SD) % 4) == 1 && (pos % SD) == 2); i++)
            applyStimulus(1'b1, rn, re, rs, rw);
        repeat (5) applyStimulus(1'b0, rn, re, rs, rw);
        repeat (6) applyStimulus(1'b1, rn, re, rs, rw);

        // Hold en low across a frame boundary while the inputs change.
        for (int i = 0; i < 64 && (pos % FRAME) != FRAME - 1; i++)
            applyStimulus(1'b1, rn, re, rs, rw);
        rn = 7'b1111110;
        rw = 7'b0000001;
        repeat (6) applyStimulus(1'b0, rn, re, rs, rw);
        repeat (FRAME + 4) applyStimulus(1'b1, rn, re, rs, rw);

        // Reset while digit 3 is being scanned.
        for (int i = 0; i < 64 && ((pos / SD) % 4) != 3; i++)
            applyStimulus(1'b1, rn, re, rs, rw);
        midCycleReset();
        repeat (FRAME + 6) applyStimulus(1'b1, rn, re, rs, rw);

        // Randomized traffic with occasional enable drops and one more reset.
        randomCycles(400, 85);
        midCycleReset();
        randomCycles(400, 70);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
